// File: rtl/mod2a_result_fifo_pkg.sv
// rtl/mod2a_result_fifo_pkg.sv - shared defaults, pointer wrap helper and occupancy encoding
// Contents: WIDTH_DEF/DEPTH_DEF defaults, ptr_inc() wrapping increment,
//           occ_op_t (HOLD/INC/DEC) and occ_op() push/pop decode.
package mod2a_result_fifo_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 8;
   localparam int PTR_MAX_W = 8;

   typedef enum logic [1:0] {
      OCC_HOLD = 2'd0,
      OCC_INC  = 2'd1,
      OCC_DEC  = 2'd2
   } occ_op_t;

   // Wraps explicitly at 'last' so non power-of-two depths would also behave.
   function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                    input logic [PTR_MAX_W-1:0] last);
      return (ptr == last) ? '0 : ptr + {{(PTR_MAX_W-1){1'b0}}, 1'b1};
   endfunction

   // Simultaneous push and pop leave occupancy unchanged.
   function automatic occ_op_t occ_op(input logic push, input logic pop);
      if (push && !pop) return OCC_INC;
      if (pop && !push) return OCC_DEC;
      return OCC_HOLD;
   endfunction

endpackage

// File: rtl/mod2a_result_fifo_fifo_ptr.sv
// rtl/mod2a_result_fifo_fifo_ptr.sv - wrapping pointer register with sync clear and enable
// Ports: clk, rst_n (async active-low), i_clr (sync, wins over i_en),
//        i_en (advance by one with wrap), o_ptr (current pointer).
module fifo_ptr
   import mod2a_result_fifo_pkg::*;
#(
   parameter int PTR_W = 3,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [PTR_W-1:0] o_ptr
);

   logic [PTR_W-1:0]     r_ptr;
   logic [PTR_MAX_W-1:0] w_next;
   logic                 w_unused_hi;

   assign w_next      = ptr_inc(PTR_MAX_W'(r_ptr), PTR_MAX_W'(DEPTH - 1));
   assign w_unused_hi = ^w_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_clr) begin
         r_ptr <= '0;
      end else if (i_en) begin
         r_ptr <= w_next[PTR_W-1:0];
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/mod2a_result_fifo.sv
// rtl/mod2a_result_fifo.sv - 8-entry result buffer with valid/ready, running sum and sticky overflow
// Ports: clk, rst_n (async active-low), clr (sync flush);
//        in_valid/in_data/in_ready producer side; out_valid/out_data/out_ready consumer side;
//        count/full/empty occupancy; overflow sticky drop flag; acc wrapping sum of accepted words.
module mod2a_result_fifo
   import mod2a_result_fifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int PTR_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   input  logic               out_ready,
   output logic [PTR_W:0]     count,
   output logic               full,
   output logic               empty,
   output logic               overflow,
   output logic [2*WIDTH-1:0] acc
);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [PTR_W:0]     r_count;
   logic               r_overflow;
   logic [2*WIDTH-1:0] r_acc;

   logic [PTR_W-1:0]   w_wr_ptr;
   logic [PTR_W-1:0]   w_rd_ptr;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;

   assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   // in_ready depends only on registered state, so a pop never frees a slot in the same cycle.
   assign w_push  = in_valid && !w_full;
   assign w_pop   = !w_empty && out_ready;

   fifo_ptr #(.PTR_W(PTR_W), .DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (clr),
      .i_en  (w_push),
      .o_ptr (w_wr_ptr)
   );

   fifo_ptr #(.PTR_W(PTR_W), .DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (clr),
      .i_en  (w_pop),
      .o_ptr (w_rd_ptr)
   );

   // Storage is deliberately unreset; only occupancy decides what is visible.
   always_ff @(posedge clk) begin
      if (w_push && !clr) begin
         r_mem[w_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_acc      <= '0;
      end else if (clr) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_acc      <= '0;
      end else begin
         case (occ_op(w_push, w_pop))
            OCC_INC: r_count <= r_count + 1'b1;
            OCC_DEC: r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (in_valid && w_full) begin
            r_overflow <= 1'b1;
         end
         if (w_push) begin
            r_acc <= r_acc + {{WIDTH{1'b0}}, in_data};
         end
      end
   end

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : r_mem[w_rd_ptr];
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_overflow;
   assign acc       = r_acc;

endmodule

// File: tb/tb_mod2a_result_fifo.sv
// tb/tb_mod2a_result_fifo.sv - directed scoreboard bench for mod2a_result_fifo
module tb_mod2a_result_fifo;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic [3:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;
   logic [31:0] acc;

   mod2a_result_fifo dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .acc       (acc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] sb[$];
   int          m_cnt = 0;
   logic [31:0] m_acc = '0;
   bit          m_ovf = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_count"},  32'(count),     32'(m_cnt));
      chk({tag, "_empty"},  32'(empty),     32'(m_cnt == 0));
      chk({tag, "_full"},   32'(full),      32'(m_cnt == 8));
      chk({tag, "_inrdy"},  32'(in_ready),  32'(m_cnt != 8));
      chk({tag, "_outvld"}, 32'(out_valid), 32'(m_cnt != 0));
      chk({tag, "_acc"},    acc,            m_acc);
      chk({tag, "_ovf"},    32'(overflow),  32'(m_ovf));
   endtask

   task automatic model_clear();
      m_cnt = 0;
      m_acc = '0;
      m_ovf = 0;
      sb.delete();
   endtask

   // One clock cycle: drive, check head/state against the model before the edge, advance.
   task automatic cyc(input bit v, input logic [15:0] d, input bit r, input bit c);
      bit do_push;
      bit do_pop;
      clr       = c;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #3;
      do_push = v && (m_cnt < 8);
      do_pop  = r && (m_cnt > 0);
      if (c) begin
         model_clear();
      end else begin
         if (do_pop) begin
            chk("head", 32'(out_data), 32'(sb[0]));
            void'(sb.pop_front());
         end
         if (do_push) begin
            sb.push_back(d);
            m_acc = m_acc + {16'h0, d};
         end
         if (v && m_cnt == 8) m_ovf = 1;
         m_cnt = m_cnt + int'(do_push) - int'(do_pop);
      end
      @(posedge clk);
      #1;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 'x;
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_state("rst");
      chk("rst_outdata", 32'(out_data), 32'h0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle with undriven data must not disturb anything.
      cyc(0, 'x, 1, 0);
      chk_state("idle");

      // Three pushes, no reads.
      cyc(1, 16'h0003, 0, 0);
      chk("first_head", 32'(out_data), 32'h0003);
      chk("first_vld",  32'(out_valid), 32'h1);
      cyc(1, 16'hFFF8, 0, 0);
      cyc(1, 16'h0010, 0, 0);
      chk("three_count", 32'(count), 32'd3);
      chk("three_acc",   acc, 32'h0001000B);
      chk_state("three");
      repeat (3) cyc(0, 'x, 1, 0);
      chk_state("drain3");

      // Fill to full, then one dropped push.
      for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 0, 0);
      cyc(1, 16'h00AA, 0, 0);
      chk("full_full",  32'(full),     32'h1);
      chk("full_inrdy", 32'(in_ready), 32'h0);
      chk("full_ovf",   32'(overflow), 32'h1);
      chk("full_count", 32'(count),    32'd8);
      // Push while full and popping: still dropped, no pass-through.
      cyc(1, 16'h00BB, 1, 0);
      chk_state("fullpop");
      while (m_cnt > 0) cyc(0, 'x, 1, 0);
      chk_state("drain8");
      chk("ovf_sticky", 32'(overflow), 32'h1);

      // Streaming at count==1 across pointer wrap.
      cyc(1, 16'h0100, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         cyc(1, 16'h0100 + 16'(i), 1, 0);
         chk("stream_count", 32'(count), 32'd1);
      end
      cyc(0, 'x, 1, 0);
      chk_state("stream_end");

      // Flush with a word presented the same cycle.
      for (int i = 0; i < 5; i++) cyc(1, 16'h0200 + 16'(i), 0, 0);
      cyc(1, 16'hDEAD, 1, 1);
      chk("clr_count", 32'(count),    32'd0);
      chk("clr_empty", 32'(empty),    32'h1);
      chk("clr_ovf",   32'(overflow), 32'h0);
      chk("clr_acc",   acc,           32'h0);
      cyc(1, 16'h5A5A, 0, 0);
      cyc(0, 'x, 1, 0);
      chk_state("post_clr");

      // Asynchronous reset between edges.
      for (int i = 0; i < 4; i++) cyc(1, 16'h0300 + 16'(i), 0, 0);
      chk("pre_arst_count", 32'(count), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      chk_state("arst");
      chk("arst_outdata", 32'(out_data), 32'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1, 16'h1234, 0, 0);
      chk("arst_head", 32'(out_data), 32'h1234);
      cyc(0, 'x, 1, 0);
      chk_state("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
